// File: rtl/mx_block_align.sv
// Block aligner ahead of the MX rounder: collects a block of FP elements, finds the
// shared (maximum) exponent, then streams each mantissa right-aligned with a sticky bit.
module mx_block_align #(
    parameter int exp_w      = 8,
    parameter int man_w      = 23,
    parameter int block_size = 32,
    parameter int width_o    = 10
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic               i_sgn,
    input  logic [exp_w-1:0]   i_exp,
    input  logic [man_w-1:0]   i_man,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_sgn,
    output logic [exp_w-1:0]   o_exp,
    output logic [width_o-1:0] o_man,
    output logic               o_last,
    output logic               o_nan
);

    localparam int FW    = man_w + 1;
    localparam int TW    = width_o - 1;
    localparam int DROP  = FW - TW;
    localparam int IDX_W = (block_size > 1) ? $clog2(block_size) : 1;
    localparam int SH_W  = $clog2(FW + 1) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(block_size - 1);

    typedef enum logic {
        COLLECT,
        EMIT
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 ready_q, ready_d;
    logic [exp_w-1:0]     blk_max_q, blk_max_d;
    logic                 blk_nan_q, blk_nan_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_sgn_q, out_sgn_d;
    logic [exp_w-1:0]     out_exp_q, out_exp_d;
    logic [width_o-1:0]   out_man_q, out_man_d;
    logic                 out_last_q, out_last_d;
    logic                 out_nan_q, out_nan_d;

    logic                 buf_sgn_q [block_size];
    logic [exp_w-1:0]     buf_exp_q [block_size];
    logic [man_w-1:0]     buf_man_q [block_size];

    logic                 accept;
    logic [exp_w-1:0]     in_eff_exp;
    logic                 in_is_nan;

    logic [exp_w-1:0]     rd_exp;
    logic [exp_w-1:0]     rd_eff_exp;
    logic [exp_w-1:0]     rd_diff;
    logic [FW-1:0]        rd_f;
    logic [SH_W-1:0]      rd_sh;
    logic [SH_W-1:0]      rd_tot;
    logic [TW-1:0]        rd_t;
    logic [FW-1:0]        rd_low_mask;
    logic                 rd_sticky;
    logic [width_o-1:0]   rd_aligned;

    assign accept     = i_valid && ready_q;
    assign in_eff_exp = (i_exp == '0) ? exp_w'(1) : i_exp;
    assign in_is_nan  = (i_exp == {exp_w{1'b1}});

    always_ff @(posedge i_clk) begin
        if (accept) begin
            buf_sgn_q[idx_q] <= i_sgn;
            buf_exp_q[idx_q] <= i_exp;
            buf_man_q[idx_q] <= i_man;
        end
    end

    // The shift saturates at TW so exponent gaps wider than the output never wrap.
    always_comb begin
        rd_exp      = buf_exp_q[idx_q];
        rd_eff_exp  = (rd_exp == '0) ? exp_w'(1) : rd_exp;
        rd_diff     = blk_max_q - rd_eff_exp;
        rd_f        = {(rd_exp != '0), buf_man_q[idx_q]};
        rd_sh       = (32'(rd_diff) >= 32'(TW)) ? SH_W'(TW) : SH_W'(rd_diff);
        rd_tot      = SH_W'(DROP) + rd_sh;
        rd_t        = TW'(rd_f >> rd_tot);
        rd_low_mask = ~({FW{1'b1}} << rd_tot);
        rd_sticky   = |(rd_f & rd_low_mask);
        rd_aligned  = {rd_t, rd_sticky};
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        blk_max_d   = blk_max_q;
        blk_nan_d   = blk_nan_q;
        out_valid_d = out_valid_q;
        out_sgn_d   = out_sgn_q;
        out_exp_d   = out_exp_q;
        out_man_d   = out_man_q;
        out_last_d  = out_last_q;
        out_nan_d   = out_nan_q;

        case (state_q)
            COLLECT: begin
                if (accept) begin
                    if (idx_q == '0) begin
                        blk_max_d = in_eff_exp;
                        blk_nan_d = in_is_nan;
                    end else begin
                        blk_max_d = (in_eff_exp > blk_max_q) ? in_eff_exp : blk_max_q;
                        blk_nan_d = blk_nan_q | in_is_nan;
                    end
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = EMIT;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            EMIT: begin
                // Once the last element sits in the output register, only its handshake matters.
                if (out_valid_q && out_last_q) begin
                    if (i_ready) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = COLLECT;
                    end
                end else if (!out_valid_q || i_ready) begin
                    out_valid_d = 1'b1;
                    out_sgn_d   = buf_sgn_q[idx_q];
                    out_exp_d   = blk_max_q;
                    out_man_d   = rd_aligned;
                    out_nan_d   = blk_nan_q;
                    out_last_d  = (idx_q == LAST_IDX);
                    idx_d       = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                end
            end
            default: state_d = COLLECT;
        endcase

        ready_d = (state_d == COLLECT);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= COLLECT;
            idx_q       <= '0;
            ready_q     <= 1'b0;
            blk_max_q   <= '0;
            blk_nan_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_sgn_q   <= 1'b0;
            out_exp_q   <= '0;
            out_man_q   <= '0;
            out_last_q  <= 1'b0;
            out_nan_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ready_q     <= ready_d;
            blk_max_q   <= blk_max_d;
            blk_nan_q   <= blk_nan_d;
            out_valid_q <= out_valid_d;
            out_sgn_q   <= out_sgn_d;
            out_exp_q   <= out_exp_d;
            out_man_q   <= out_man_d;
            out_last_q  <= out_last_d;
            out_nan_q   <= out_nan_d;
        end
    end

    assign o_ready = ready_q;
    assign o_valid = out_valid_q;
    assign o_sgn   = out_sgn_q;
    assign o_exp   = out_exp_q;
    assign o_man   = out_man_q;
    assign o_last  = out_last_q;
    assign o_nan   = out_nan_q;

endmodule
